// File: rtl/ring_flit_pkg.sv
// Ring flit framing shared by the directory-controller reply upload and download blocks.
// Flit/message geometry, ctrl codes and download FSM encoding.
package ring_flit_pkg;

  localparam int FLIT_W    = 16;
  localparam int MAX_FLITS = 11;
  localparam int MSG_W     = FLIT_W * MAX_FLITS;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_FULL = ST_FULL
  } dl_state_t;

  localparam logic [3:0] CNT_MAX = 4'(MAX_FLITS);
  localparam logic [3:0] NUM_MAX = 4'(MAX_FLITS - 1);

endpackage

// File: rtl/dc_rep_download_if.sv
// Flit stream in / assembled reply out bundle for dc_rep_download.
// slave = download block, master = ring FIFO plus reply consumer.
interface dc_rep_download_if;
  import ring_flit_pkg::*;

  logic [FLIT_W-1:0] flit_in;
  logic              v_flit_in;
  logic [1:0]        ctrl_in;
  logic              flit_rdy;
  logic [MSG_W-1:0]  flits_rep;
  logic              v_flits_rep;
  logic [3:0]        flits_num;
  logic              rep_taken;

  modport master (
    output flit_in, v_flit_in, ctrl_in, rep_taken,
    input  flit_rdy, flits_rep, v_flits_rep, flits_num
  );

  modport slave (
    input  flit_in, v_flit_in, ctrl_in, rep_taken,
    output flit_rdy, flits_rep, v_flits_rep, flits_num
  );

endinterface

// File: rtl/flit_slot_writer.sv
// Inserts one flit into slot idx of a left-aligned message vector.
// Slot k occupies [MSG_W-1-FLIT_W*k -: FLIT_W]; idx >= MAX_FLITS writes nothing.
module flit_slot_writer
  import ring_flit_pkg::*;
(
  input  logic [MSG_W-1:0]  base,
  input  logic [FLIT_W-1:0] flit,
  input  logic [3:0]        idx,
  output logic [MSG_W-1:0]  vec
);

  always_comb begin
    vec = base;
    for (int k = 0; k < MAX_FLITS; k++) begin
      if (idx == 4'(k))
        vec[MSG_W-1-FLIT_W*k -: FLIT_W] = flit;
    end
  end

endmodule

// File: rtl/dc_rep_download.sv
// Reply download: reassembles head/body/tail flits into one held message.
// Optional err_cnt output enabled by DC_REP_DOWNLOAD_ERR_CNT_EN.
module dc_rep_download
  import ring_flit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dc_rep_download_if.slave  bus,
  output logic [1:0]        dc_rep_download_state,
  output logic              err_flag
`ifdef DC_REP_DOWNLOAD_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  dl_state_t        state, state_n;
  logic [MSG_W-1:0] rep, rep_n;
  logic             v_rep, v_rep_n;
  logic [3:0]       num, num_n;
  logic [3:0]       cnt, cnt_n;
  logic             err_n;

  logic             rdy;
  logic             acc;
  logic             append;
  logic [MSG_W-1:0] wr_base;
  logic [3:0]       wr_idx;
  logic [MSG_W-1:0] wr_vec;

  assign rdy = (state != S_FULL);
  assign acc = bus.v_flit_in && rdy && (bus.ctrl_in != CTRL_IDLE);

  // Only a body/tail in BUSY extends the message; all else starts at slot 0
  assign append  = (state == S_BUSY) && (bus.ctrl_in != CTRL_HEAD);
  assign wr_base = append ? rep : '0;
  assign wr_idx  = append ? cnt : 4'd0;

  flit_slot_writer u_wr (
    .base (wr_base),
    .flit (bus.flit_in),
    .idx  (wr_idx),
    .vec  (wr_vec)
  );

  always_comb begin
    state_n = state;
    rep_n   = rep;
    v_rep_n = v_rep;
    num_n   = num;
    cnt_n   = cnt;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          unique case (bus.ctrl_in)
            CTRL_HEAD: begin
              rep_n   = wr_vec;
              cnt_n   = 4'd1;
              state_n = S_BUSY;
            end
            CTRL_TAIL: begin
              rep_n   = wr_vec;
              num_n   = 4'd0;
              v_rep_n = 1'b1;
              state_n = S_FULL;
            end
            default: err_n = 1'b1;
          endcase
        end
      end
      S_BUSY: begin
        if (acc) begin
          unique case (bus.ctrl_in)
            CTRL_HEAD: begin
              err_n = 1'b1;
              rep_n = wr_vec;
              cnt_n = 4'd1;
            end
            CTRL_BODY: begin
              if (cnt == CNT_MAX) begin
                err_n = 1'b1;
              end else begin
                rep_n = wr_vec;
                cnt_n = cnt + 4'd1;
              end
            end
            default: begin
              // Overflowed tail still closes the message
              if (cnt == CNT_MAX) begin
                err_n = 1'b1;
                num_n = NUM_MAX;
              end else begin
                rep_n = wr_vec;
                num_n = cnt;
              end
              v_rep_n = 1'b1;
              state_n = S_FULL;
            end
          endcase
        end
      end
      default: begin
        v_rep_n = 1'b1;
        if (bus.rep_taken) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
          v_rep_n = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rep      <= '0;
      v_rep    <= 1'b0;
      num      <= 4'd0;
      cnt      <= 4'd0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_n;
      rep      <= rep_n;
      v_rep    <= v_rep_n;
      num      <= num_n;
      cnt      <= cnt_n;
      err_flag <= err_n;
    end
  end

`ifdef DC_REP_DOWNLOAD_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= 8'd0;
    else if (err_flag && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

  assign bus.flit_rdy    = rdy;
  assign bus.flits_rep   = rep;
  assign bus.v_flits_rep = v_rep;
  assign bus.flits_num   = num;
  assign dc_rep_download_state = state;

endmodule

// File: tb/tb_dc_rep_download.sv
// Scoreboard bench for dc_rep_download: directed flit sequences,
// expected messages and error pulses queued and checked by a monitor.
module tb_dc_rep_download;
  import ring_flit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st;
  logic       err_flag;
`ifdef DC_REP_DOWNLOAD_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  dc_rep_download_if bus ();

  dc_rep_download dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus                   (bus.slave),
    .dc_rep_download_state (st),
    .err_flag              (err_flag)
`ifdef DC_REP_DOWNLOAD_ERR_CNT_EN
    ,
    .err_cnt               (err_cnt)
`endif
  );

  typedef struct {
    logic [MSG_W-1:0] rep;
    logic [3:0]       num;
    int               cyc;
  } msg_t;

  msg_t mq[$];
  int   eq[$];
  msg_t m;
  int   ecyc;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [MSG_W-1:0] got,
                     input logic [MSG_W-1:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: pops expectations whenever a message or error pulse appears
  always @(negedge clk) begin
    if (bus.v_flits_rep && !prev_v) begin
      if (mq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_msg: got %h expected none", bus.flits_rep);
      end else begin
        m = mq.pop_front();
        chk("msg_rep", bus.flits_rep, m.rep);
        chk("msg_num", MSG_W'(bus.flits_num), MSG_W'(m.num));
        chk("msg_latency", MSG_W'(cyc), MSG_W'(m.cyc));
      end
    end
    if (err_flag) begin
      if (eq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_err: got pulse at cycle %0d expected none", cyc);
      end else begin
        ecyc = eq.pop_front();
        chk("err_cycle", MSG_W'(cyc), MSG_W'(ecyc));
      end
    end
    prev_v <= bus.v_flits_rep;
  end

  task automatic drive(input logic [1:0] c, input logic [15:0] f);
    bus.v_flit_in = 1'b1;
    bus.ctrl_in   = c;
    bus.flit_in   = f;
    @(posedge clk);
    #1;
    bus.v_flit_in = 1'b0;
    bus.ctrl_in   = CTRL_IDLE;
  endtask

  task automatic take();
    bus.rep_taken = 1'b1;
    @(posedge clk);
    #1;
    bus.rep_taken = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_msg(input logic [MSG_W-1:0] r, input logic [3:0] n);
    msg_t e;
    e.rep = r;
    e.num = n;
    e.cyc = cyc;
    mq.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, MSG_W'(st), MSG_W'(ST_IDLE));
    chk({tag, "_rdy"}, MSG_W'(bus.flit_rdy), MSG_W'(1));
    chk({tag, "_v"}, MSG_W'(bus.v_flits_rep), MSG_W'(0));
    chk({tag, "_rep"}, bus.flits_rep, '0);
    chk({tag, "_num"}, MSG_W'(bus.flits_num), MSG_W'(0));
    chk({tag, "_err"}, MSG_W'(err_flag), MSG_W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MSG_W-1:0] e;
    rst           = 1'b1;
    bus.flit_in   = '0;
    bus.v_flit_in = 1'b0;
    bus.ctrl_in   = CTRL_IDLE;
    bus.rep_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset");

    // 3-flit message
    drive(CTRL_HEAD, 16'hA001);
    drive(CTRL_BODY, 16'hB002);
    drive(CTRL_TAIL, 16'hC003);
    push_msg({48'hA001_B002_C003, 128'h0}, 4'd2);
    chk("full_state", MSG_W'(st), MSG_W'(ST_FULL));
    take();
    chk("taken_state", MSG_W'(st), MSG_W'(ST_IDLE));

    // valid with ctrl 00 is ignored
    drive(CTRL_IDLE, 16'hFFFF);
    chk("idle_ctrl_state", MSG_W'(st), MSG_W'(ST_IDLE));

    // single flit, then hold with a head offered
    drive(CTRL_TAIL, 16'h1234);
    push_msg({16'h1234, 160'h0}, 4'd0);
    bus.v_flit_in = 1'b1;
    bus.ctrl_in   = CTRL_HEAD;
    bus.flit_in   = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_rdy", MSG_W'(bus.flit_rdy), MSG_W'(0));
      chk("hold_rep", bus.flits_rep, {16'h1234, 160'h0});
    end
    take();
    chk("hold_not_acc", MSG_W'(st), MSG_W'(ST_IDLE));
    @(posedge clk);
    #1;
    bus.v_flit_in = 1'b0;
    bus.ctrl_in   = CTRL_IDLE;
    chk("hold_head_acc", MSG_W'(st), MSG_W'(ST_BUSY));
    drive(CTRL_TAIL, 16'h6666);
    push_msg({32'h5555_6666, 144'h0}, 4'd1);
    take();

    // body in IDLE
    drive(CTRL_BODY, 16'hDEAD);
    eq.push_back(cyc);
    chk("idle_body_state", MSG_W'(st), MSG_W'(ST_IDLE));

    // head, body, head, tail
    drive(CTRL_HEAD, 16'h1111);
    drive(CTRL_BODY, 16'h2222);
    drive(CTRL_HEAD, 16'h3333);
    eq.push_back(cyc);
    drive(CTRL_TAIL, 16'h4444);
    push_msg({32'h3333_4444, 144'h0}, 4'd1);
    take();

    // full 11-flit message
    e = '0;
    for (int k = 0; k < MAX_FLITS; k++)
      e[MSG_W-1-16*k -: 16] = 16'h0100 + 16'(k);
    drive(CTRL_HEAD, 16'h0100);
    for (int k = 1; k < 10; k++) drive(CTRL_BODY, 16'h0100 + 16'(k));
    drive(CTRL_TAIL, 16'h010A);
    push_msg(e, 4'd10);
    chk("max_slot10", MSG_W'(bus.flits_rep[15:0]), MSG_W'(16'h010A));
    take();

    // overflow: extra body and tail beyond 11 flits
    e = '0;
    for (int k = 0; k < MAX_FLITS; k++)
      e[MSG_W-1-16*k -: 16] = 16'h0200 + 16'(k);
    drive(CTRL_HEAD, 16'h0200);
    for (int k = 1; k <= 10; k++) drive(CTRL_BODY, 16'h0200 + 16'(k));
    drive(CTRL_BODY, 16'h0BAD);
    eq.push_back(cyc);
    chk("ovf_body_state", MSG_W'(st), MSG_W'(ST_BUSY));
    drive(CTRL_TAIL, 16'h0FFF);
    eq.push_back(cyc);
    push_msg(e, 4'd10);
    take();

    // reset mid-message
    drive(CTRL_HEAD, 16'h7777);
    drive(CTRL_BODY, 16'h8888);
`ifdef DC_REP_DOWNLOAD_ERR_CNT_EN
    chk("err_cnt", MSG_W'(err_cnt), MSG_W'(4));
`endif
    pulse_rst();
    chk_reset_vals("midrst");
`ifdef DC_REP_DOWNLOAD_ERR_CNT_EN
    chk("err_cnt_rst", MSG_W'(err_cnt), MSG_W'(0));
`endif
    drive(CTRL_HEAD, 16'h9999);
    drive(CTRL_TAIL, 16'hAAAA);
    push_msg({32'h9999_AAAA, 144'h0}, 4'd1);
    take();

    repeat (3) @(posedge clk);
    #1;
    chk("msgs_left", MSG_W'(mq.size()), MSG_W'(0));
    chk("errs_left", MSG_W'(eq.size()), MSG_W'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
